// File: rtl/seg_scan6_pkg.sv
// Shared constants and types for the six-digit multiplexed 7-segment scanner.
//
// Contents:
//   NUM_DIGITS  - number of multiplexed digit positions
//   GUARD       - prescaler cycles at the start of each slot with all commons off
//   SEG_0..SEG_9, SEG_BLANK - active-low {g,f,e,d,c,b,a} segment patterns
//   seg_src_e   - which blanking rule (if any) decides the segment output
//   com_onehot  - active-low one-hot common for a digit index
package seg_scan6_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned GUARD      = 2;

  localparam logic [2:0]  LAST_IDX   = 3'(NUM_DIGITS - 1);

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Blanking sources in descending priority; SRC_DIGIT means the decoded
  // digit is shown.
  typedef enum logic [2:0] {
    SRC_GUARD,
    SRC_BLINK,
    SRC_LZ,
    SRC_INVALID,
    SRC_DIGIT
  } seg_src_e;

  function automatic logic [5:0] com_onehot(input logic [2:0] idx);
    logic [5:0] r;
    r = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 3'(i)) r[i] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan6_bcd_to_seg7.sv
// BCD to 7-segment decoder (combinational).
//
// Ports:
//   bcd  in  4  BCD digit value
//   seg  out 7  active-low {g,f,e,d,c,b,a}; all segments off for 10-15
module bcd_to_seg7
  import seg_scan6_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan6.sv
// Six-digit multiplexed 7-segment display scanner (HH:MM:SS style).
//
// A prescaler divides in_clk into digit slots; each slot lights one common
// after a short all-off guard period. The six BCD digits are captured once
// per frame so a digit update never tears across a frame. Digits selected by
// blink_mask are blanked during alternate blink half-periods, and the colon
// dots (dp on indices 4 and 2) are lit only during the visible blink phase.
//
// Parameters:
//   SCAN_DIV   in_clk cycles per digit slot (>= 4)
//   BLINK_DIV  full frames per blink half-period (>= 1)
//
// Ports:
//   in_clk      in   1  clock, rising edge
//   rst         in   1  asynchronous reset, active low
//   digits      in  24  six BCD digits, [23:20] = index 5 .. [3:0] = index 0
//   blank_lz    in   1  suppress a zero in index 5
//   blink_mask  in   6  bit i set: digit i blinks
//   seg         out  7  active-low segments {g,f,e,d,c,b,a}, registered
//   dp          out  1  active-low decimal point, registered
//   com         out  6  active-low one-hot commons, registered
module seg_scan6
  import seg_scan6_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLINK_DIV = 250
) (
  input  logic        in_clk,
  input  logic        rst,
  input  logic [23:0] digits,
  input  logic        blank_lz,
  input  logic [5:0]  blink_mask,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  com
);

  localparam int unsigned PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PCNT_GRD  = PW'(GUARD);
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_DIV - 1);

  // Counter and latch state
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [23:0]   frame_q, frame_d;

  // Output registers
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [5:0]    com_q, com_d;

  // Per-slot decode
  logic          slot_end;
  logic          frame_end;
  logic          guard;
  logic [3:0]    cur_bcd;
  logic          cur_blink;
  logic [6:0]    dec_seg;
  seg_src_e      src;

  assign slot_end  = (pcnt_q == PCNT_LAST);
  assign frame_end = slot_end && (idx_q == LAST_IDX);
  assign guard     = (pcnt_q < PCNT_GRD);

  // Counters and frame latch
  always_comb begin
    pcnt_d        = slot_end ? '0 : pcnt_q + PW'(1);
    idx_d         = idx_q;
    fcnt_d        = fcnt_q;
    blink_phase_d = blink_phase_q;
    frame_d       = frame_q;

    if (slot_end) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 3'd1;
    end

    // Capture happens on the last cycle of index 5, so the output computed
    // on that cycle still uses the old frame and index 0 sees the new one.
    if (frame_end) begin
      frame_d = digits;
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d        = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  // Select the latched digit and live blink bit for the current index
  always_comb begin
    cur_bcd   = '0;
    cur_blink = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        cur_bcd   = frame_q[i*4 +: 4];
        cur_blink = blink_mask[i];
      end
    end
  end

  bcd_to_seg7 u_dec (
    .bcd (cur_bcd),
    .seg (dec_seg)
  );

  // Blanking priority: guard > blink > leading zero > invalid BCD > decode
  always_comb begin
    src = SRC_DIGIT;
    if (guard) begin
      src = SRC_GUARD;
    end else if (blink_phase_q && cur_blink) begin
      src = SRC_BLINK;
    end else if ((idx_q == LAST_IDX) && blank_lz && (cur_bcd == 4'd0)) begin
      src = SRC_LZ;
    end else if (cur_bcd > 4'd9) begin
      src = SRC_INVALID;
    end
  end

  // Output next-state
  always_comb begin
    seg_d = (src == SRC_DIGIT) ? dec_seg : SEG_BLANK;
    com_d = guard ? '1 : com_onehot(idx_q);
    dp_d  = 1'b1;
    // Colon dots sit after the hour and minute digits and blink with phase.
    if (!guard && !blink_phase_q && ((idx_q == 3'd4) || (idx_q == 3'd2))) begin
      dp_d = 1'b0;
    end
  end

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      pcnt_q        <= '0;
      idx_q         <= '0;
      fcnt_q        <= '0;
      blink_phase_q <= 1'b0;
      frame_q       <= '0;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      com_q         <= '1;
    end else begin
      pcnt_q        <= pcnt_d;
      idx_q         <= idx_d;
      fcnt_q        <= fcnt_d;
      blink_phase_q <= blink_phase_d;
      frame_q       <= frame_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      com_q         <= com_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign com = com_q;

endmodule

// File: tb/tb_seg_scan6.sv
// Self-checking bench for seg_scan6 with SCAN_DIV=8, BLINK_DIV=2.
// A cycle-arithmetic model predicts seg/dp/com after every clock edge; a
// directed sequence adds hand-computed literal expectations.
module tb_seg_scan6;

  localparam int unsigned SD = 8;
  localparam int unsigned BD = 2;
  localparam int unsigned FR = 6 * SD;

  logic        in_clk;
  logic        rst;
  logic [23:0] digits;
  logic        blank_lz;
  logic [5:0]  blink_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  com;

  seg_scan6 #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .in_clk     (in_clk),
    .rst        (rst),
    .digits     (digits),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .seg        (seg),
    .dp         (dp),
    .com        (com)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0]  seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int unsigned m;          // cycles since reset release, before this edge
  logic [23:0] mlatch;
  int unsigned m_pc, m_id, m_fr, m_ph;
  logic [3:0]  m_v;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [5:0]  e_com;

  always @(posedge in_clk) begin
    if (!rst) begin
      m      = 0;
      mlatch = '0;
      e_seg  = 7'h7F;
      e_dp   = 1'b1;
      e_com  = 6'h3F;
    end else begin
      m_pc = m % SD;
      m_id = (m / SD) % 6;
      m_fr = m / FR;
      m_ph = (m_fr / BD) % 2;
      if (m_pc < 2) begin
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_com = 6'h3F;
      end else begin
        e_com       = 6'h3F;
        e_com[m_id] = 1'b0;
        e_dp        = (m_ph == 0 && (m_id == 2 || m_id == 4)) ? 1'b0 : 1'b1;
        m_v         = mlatch[m_id*4 +: 4];
        if (m_ph == 1 && blink_mask[m_id])            e_seg = 7'h7F;
        else if (m_id == 5 && blank_lz && m_v == 4'd0) e_seg = 7'h7F;
        else if (m_v > 4'd9)                           e_seg = 7'h7F;
        else                                           e_seg = seg_tab[m_v];
      end
      if (m % FR == FR - 1) mlatch = digits;
      m++;
    end
    #1;
    chk("model_seg", {25'd0, seg}, {25'd0, e_seg});
    chk("model_dp",  {31'd0, dp},  {31'd0, e_dp});
    chk("model_com", {26'd0, com}, {26'd0, e_com});
  end

  // ---------------- directed sequence ----------------
  int unsigned k;          // edges since release; outputs reflect cycle k-1

  task automatic step();
    @(posedge in_clk);
    #2;
    k++;
  endtask

  task automatic goto(input int unsigned kt);
    if (k > kt) chk("goto_order", k, kt);
    while (k < kt) step();
  endtask

  task automatic cs(input string name, input int unsigned f, input int unsigned i,
                    input logic [6:0] exp);
    goto(f * FR + i * SD + 5);
    chk(name, {25'd0, seg}, {25'd0, exp});
  endtask

  task automatic cdp(input string name, input int unsigned f, input int unsigned i,
                     input logic exp);
    goto(f * FR + i * SD + 5);
    chk(name, {31'd0, dp}, {31'd0, exp});
  endtask

  logic [6:0]  scan_exp [0:5] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
  int unsigned com_low  [0:5];

  initial begin
    rst        = 1'b0;
    digits     = '0;
    blank_lz   = 1'b0;
    blink_mask = '0;
    k          = 0;
    repeat (3) @(posedge in_clk);
    #2;
    chk("reset_seg", {25'd0, seg}, 32'h7F);
    chk("reset_com", {26'd0, com}, 32'h3F);
    chk("reset_dp",  {31'd0, dp},  32'h1);

    @(negedge in_clk);
    rst    = 1'b1;
    k      = 0;
    digits = 24'h123456;

    step(); chk("guard_k1", {26'd0, com}, 32'h3F);
    step(); chk("guard_k2", {26'd0, com}, 32'h3F);
    step(); chk("com0_first_k3", {26'd0, com}, 32'h3E);

    cs("frame0_idx0_zero", 0, 0, 7'h40);
    cs("frame0_idx5_zero", 0, 5, 7'h40);

    for (int s = 0; s < 6; s++) com_low[s] = 0;
    for (int unsigned kk = FR + 1; kk <= 2 * FR; kk++) begin
      int unsigned slot, pc;
      goto(kk);
      slot = (kk - FR - 1) / SD;
      pc   = (kk - FR - 1) % SD;
      if (com != 6'h3F) com_low[slot]++;
      if (pc == 4) begin
        chk("scan_seg", {25'd0, seg}, {25'd0, scan_exp[slot]});
        chk("scan_dp", {31'd0, dp}, (slot == 2 || slot == 4) ? 32'h0 : 32'h1);
      end
    end
    for (int s = 0; s < 6; s++) chk("com_low_count", com_low[s], 6);

    // change digits mid-frame during slot 2 of frame 2
    goto(2 * FR + 2 * SD + 4);
    digits = 24'h000000;
    cs("tear_idx3", 2, 3, 7'h30);
    cs("tear_idx4", 2, 4, 7'h24);
    cdp("phase1_dp_idx4", 2, 4, 1'b1);
    cs("tear_idx5", 2, 5, 7'h79);
    cs("next_idx0_zero", 3, 0, 7'h40);
    cs("next_idx5_zero", 3, 5, 7'h40);

    digits   = 24'h095959;
    blank_lz = 1'b1;
    cs("lz_idx0", 4, 0, 7'h10);
    cs("lz_idx3", 4, 3, 7'h12);
    cs("lz_idx4", 4, 4, 7'h10);
    cdp("phase0_dp_idx4", 4, 4, 1'b0);
    cs("lz_idx5_blank", 4, 5, 7'h7F);
    blank_lz = 1'b0;
    cs("nolz_idx5_zero", 5, 5, 7'h40);
    chk("pre_reset_com", {26'd0, com}, 32'h1F);

    // asynchronous reset mid-slot
    #1 rst = 1'b0;
    #1;
    chk("async_seg", {25'd0, seg}, 32'h7F);
    chk("async_com", {26'd0, com}, 32'h3F);
    chk("async_dp",  {31'd0, dp},  32'h1);
    blink_mask = 6'b000011;
    repeat (3) step();
    @(negedge in_clk);
    rst = 1'b1;
    k   = 0;

    cs("blink_f0_idx0", 0, 0, 7'h40);
    cs("blink_f0_idx1", 0, 1, 7'h40);
    cdp("blink_f0_dp4", 0, 4, 1'b0);
    cs("blink_f1_idx0", 1, 0, 7'h10);
    cs("blink_f1_idx1", 1, 1, 7'h12);
    cs("blink_f2_idx0", 2, 0, 7'h7F);
    cs("blink_f2_idx1", 2, 1, 7'h7F);
    cs("blink_f2_idx2", 2, 2, 7'h10);
    cdp("blink_f2_dp2", 2, 2, 1'b1);
    cs("blink_f3_idx0", 3, 0, 7'h7F);
    cs("blink_f3_idx1", 3, 1, 7'h7F);
    cs("blink_f4_idx0", 4, 0, 7'h10);
    cs("blink_f4_idx1", 4, 1, 7'h12);
    cdp("blink_f4_dp4", 4, 4, 1'b0);
    cs("blink_f5_idx0", 5, 0, 7'h10);
    cs("blink_f5_idx1", 5, 1, 7'h12);

    digits     = 24'h09595C;
    blink_mask = '0;
    cs("bad_bcd_idx0", 6, 0, 7'h7F);
    cs("bad_bcd_idx1", 6, 1, 7'h12);
    cs("bad_bcd_idx2", 6, 2, 7'h10);
    cs("bad_bcd_idx5", 6, 5, 7'h40);

    repeat (4) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, required < 200000", $time);
    $fatal(1);
  end

endmodule

// File: doc/seg_scan6.md
SEG_SCAN6 -- requirements
Module: seg_scan6

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning in_clk cycles per digit slot (minimum 4).
REQ-002 SHALL have parameter BLINK_DIV, default 250, meaning full scan frames per blink half-period (minimum 1).
REQ-003 SHALL have port in_clk  input  1  system clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port digits  input  24  six BCD digits; [23:20] hour tens (index 5) down to [3:0] second ones (index 0).
REQ-006 SHALL have port blank_lz  input  1  1 = suppress a zero hour-tens digit.
REQ-007 SHALL have port blink_mask  input  6  bit i set = digit i blinks.
REQ-008 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-009 SHALL have port dp  output  1  decimal point, active-low, registered.
REQ-010 SHALL have port com  output  6  digit commons, one-hot active-low, registered.

Function
REQ-011 SHALL hold a prescaler pcnt counting 0..SCAN_DIV-1 and wrapping to 0.
REQ-012 SHALL advance digit index idx 0->1->...->5->0 on the cycle pcnt wraps.
REQ-013 SHALL snapshot digits into an internal frame latch on the cycle idx wraps 5->0; inputs changing mid-frame SHALL NOT affect the current frame.
REQ-014 SHALL drive com all-ones (guard) while pcnt < 2, then com[idx]=0, others 1, for the rest of the slot.
REQ-015 SHALL register seg/dp/com with 1 cycle latency from the idx/pcnt values that produce them.
REQ-016 SHALL decode latched BCD 0-9 to standard 7-segment patterns; values 10-15 SHALL give seg=7'h7F (blank).
REQ-017 SHALL blank index 5 (seg=7'h7F) when blank_lz=1 and its latched value is 0.
REQ-018 SHALL keep frame counter fcnt 0..BLINK_DIV-1, incremented on each idx 5->0 wrap; on its wrap it SHALL toggle blink_phase.
REQ-019 SHALL blank digit i when blink_phase=1 and blink_mask[i]=1; blink_mask is sampled live, not latched.
REQ-020 SHALL drive dp=0 on indices 4 and 2 when blink_phase=0, else dp=1.
REQ-021 SHALL make dp follow blanking: dp=1 whenever com is all-ones.
REQ-022 SHALL apply blanking rules in priority: guard > blink > leading-zero > invalid-BCD > decode.

Reset
REQ-023 SHALL, while rst=0, force pcnt=0, idx=0, fcnt=0, blink_phase=0, frame latch=0, seg=7'h7F, dp=1, com=6'h3F.
REQ-024 SHALL apply reset asynchronously at any point, including mid-slot or mid-frame; after release, first slot SHALL be index 0 with the guard active.
REQ-025 SHALL show zeros in the first frame after reset until the first 5->0 wrap captures digits.

Structure
REQ-026 SHALL place NUM_DIGITS=6, GUARD=2 and the ten segment pattern constants in the shared clock package.
REQ-027 SHALL instantiate one combinational sub-module bcd_to_seg7 (4-bit in, 7-bit active-low out, 7'h7F for 10-15).
REQ-028 SHALL contain no other sub-modules; all counters and registers live in seg_scan6.

Verification (SCAN_DIV=8, BLINK_DIV=2)
REQ-029 SHALL check reset: rst=0 mid-slot -> same-cycle seg=7'h7F, com=6'h3F, dp=1; after release, com[0]=0 first at cycle 3.
REQ-030 SHALL check scan: digits=24'h123456 after first wrap -> slots show 6,5,4,3,2,1 in that order; com low for exactly 6 of 8 cycles per slot.
REQ-031 SHALL check tearing: change digits to 24'h000000 during slot 2 -> slots 3-5 still show 3,2,1; next frame shows zeros.
REQ-032 SHALL check leading zero: digits=24'h095959, blank_lz=1 -> index 5 seg=7'h7F; blank_lz=0 -> index 5 seg = pattern for 0.
REQ-033 SHALL check blink: blink_mask=6'b000011 -> indices 0,1 blank in frames 2-3, lit in frames 0-1 and 4-5; dp on 4 and 2 low only in phase-0 frames.
REQ-034 SHALL check invalid BCD: digits[3:0]=4'hC -> index 0 seg=7'h7F, other digits unaffected.
